// File: rtl/fifo_level_ctrl_pkg.sv
// Shared FIFO sizing defaults, reused by the datapath FIFO wrappers so every
// instance agrees on depth and watermark levels.
package fifo_level_ctrl_pkg;

    localparam int unsigned FifoAddrWidth = 4;
    localparam int unsigned FifoAeLevel   = 1;
    localparam int unsigned FifoAfLevel   = (2 ** FifoAddrWidth) - 1;

endpackage

// File: rtl/fifo_level_ctrl.sv
// FIFO pointer/level controller: tracks read/write pointers, occupancy, watermark
// status and sticky overflow/underflow flags for an external synchronous-read RAM.
module fifo_level_ctrl
    import fifo_level_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FifoAddrWidth,
    parameter int unsigned AE_LEVEL   = FifoAeLevel,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH-1:0] r_addr_next,
    output logic                  w_en,
    output logic                  r_en,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;

    localparam logic [LW-1:0] LevelDepth = LW'(DEPTH);
    localparam logic [LW-1:0] LevelAe    = LW'(AE_LEVEL);
    localparam logic [LW-1:0] LevelAf    = LW'(AF_LEVEL);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_params
        $error("fifo_level_ctrl: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  empty_q, full_q, almost_empty_q, almost_full_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  ovf_event, udf_event;

    // A read frees a slot in the same cycle, so a full FIFO still accepts rd & wr.
    assign w_en = wr & ~flush & (~full_q | rd);
    assign r_en = rd & ~flush & ~empty_q;

    assign ovf_event = wr & ~flush & full_q & ~rd;
    assign udf_event = rd & ~flush & empty_q & ~wr;

    always_comb begin
        w_addr_d    = w_addr_q;
        r_addr_d    = r_addr_q;
        level_d     = level_q;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;

        if (flush) begin
            w_addr_d = '0;
            r_addr_d = '0;
            level_d  = '0;
        end else begin
            if (w_en) begin
                w_addr_d = w_addr_q + 1'b1;
            end
            if (r_en) begin
                r_addr_d = r_addr_q + 1'b1;
            end
            unique case ({w_en, r_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A new error wins over a same-cycle clear.
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
        if (udf_event) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_addr_q       <= '0;
            r_addr_q       <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            w_addr_q       <= w_addr_d;
            r_addr_q       <= r_addr_d;
            level_q        <= level_d;
            empty_q        <= (level_d == '0);
            full_q         <= (level_d == LevelDepth);
            almost_empty_q <= (level_d <= LevelAe);
            almost_full_q  <= (level_d >= LevelAf);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_addr_next  = r_addr_d;
    assign w_addr       = w_addr_q;
    assign r_addr       = r_addr_q;
    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level_ctrl.sv
// Directed self-checking bench for fifo_level_ctrl at default parameters
// (DEPTH 16, almost_empty at level <= 1, almost_full at level >= 15).
module tb_fifo_level_ctrl;

    logic       clk;
    logic       reset_n;
    logic       rd, wr, flush, clr_err;
    logic [3:0] w_addr, r_addr, r_addr_next;
    logic       w_en, r_en;
    logic       empty, full, almost_empty, almost_full;
    logic [4:0] level;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;

    fifo_level_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd           (rd),
        .wr           (wr),
        .flush        (flush),
        .clr_err      (clr_err),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .r_addr_next  (r_addr_next),
        .w_en         (w_en),
        .r_en         (r_en),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic f, input logic c);
        rd      = r;
        wr      = w;
        flush   = f;
        clr_err = c;
        #1;
    endtask

    task automatic chk_status(input string tag, input int lvl, input int wa, input int ra);
        chk({tag, ".level"}, int'(level), lvl);
        chk({tag, ".w_addr"}, int'(w_addr), wa);
        chk({tag, ".r_addr"}, int'(r_addr), ra);
        chk({tag, ".empty"}, int'(empty), int'(lvl == 0));
        chk({tag, ".full"}, int'(full), int'(lvl == 16));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(lvl <= 1));
        chk({tag, ".almost_full"}, int'(almost_full), int'(lvl >= 15));
    endtask

    initial begin
        reset_n = 1'b0;
        rd = 1'b0; wr = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #12;

        // Reset state, and combinational outputs reacting to inputs under reset.
        chk_status("reset", 0, 0, 0);
        chk("reset.overflow", int'(overflow), 0);
        chk("reset.underflow", int'(underflow), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset.w_en", int'(w_en), 1);
        chk("reset.r_en", int'(r_en), 0);
        chk("reset.r_addr_next", int'(r_addr_next), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();

        // Fill to DEPTH.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk("fill.w_en", int'(w_en), 1);
            tick();
            chk_status("fill", i + 1, (i + 1) % 16, 0);
        end

        // Write while full without read: dropped, overflow sticky.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovf.w_en", int'(w_en), 0);
        tick();
        chk_status("ovf", 16, 0, 0);
        chk("ovf.overflow", int'(overflow), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf.hold", int'(overflow), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovf.clr", int'(overflow), 0);

        // Full, rd & wr together for 20 cycles: pointers wrap, level holds.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rw_full.w_en", int'(w_en), 1);
            chk("rw_full.r_en", int'(r_en), 1);
            chk("rw_full.r_addr_next", int'(r_addr_next), (i + 1) % 16);
            tick();
            chk("rw_full.full", int'(full), 1);
            chk("rw_full.level", int'(level), 16);
            chk("rw_full.overflow", int'(overflow), 0);
        end
        chk_status("rw_full_end", 16, 4, 4);

        // Flush: pointers and level cleared.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush.r_addr_next", int'(r_addr_next), 0);
        tick();
        chk_status("flush", 0, 0, 0);

        // Read while empty: dropped, underflow sticky; clear loses to a new error.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("udf.r_en", int'(r_en), 0);
        chk("udf.r_addr_next", int'(r_addr_next), 0);
        tick();
        chk_status("udf", 0, 0, 0);
        chk("udf.underflow", int'(underflow), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("udf.clr_vs_new", int'(underflow), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("udf.clr", int'(underflow), 0);

        // Empty, rd & wr together: only the write is accepted.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rw_empty.w_en", int'(w_en), 1);
        chk("rw_empty.r_en", int'(r_en), 0);
        tick();
        chk_status("rw_empty", 1, 1, 0);
        chk("rw_empty.underflow", int'(underflow), 0);

        // Up to level 7, then flush together with wr.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_status("lvl7", 7, 7, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("flush_wr.w_en", int'(w_en), 0);
        tick();
        chk_status("flush_wr", 0, 0, 0);

        // Raise overflow-free occupancy and a sticky flag, then reset mid-burst.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_status("pre_rst", 5, 5, 0);
        chk("pre_rst.underflow", int'(underflow), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_status("async_rst", 0, 0, 0);
        chk("async_rst.underflow", int'(underflow), 0);
        chk("async_rst.overflow", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst.r_en", int'(r_en), 0);
        tick();
        chk_status("post_rst", 1, 1, 0);
        chk("post_rst.underflow", int'(underflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
